pkt_tx_engine: RTL

Transmit-side endpoint of the credit-based packet bus. It accepts payload/control beats from a local source over a valid/ready handshake and buffers them in a small FIFO. It drives the bus transmit word and valid, appends even parity and spends one credit per beat. Credits come back from the receiving end as single-cycle pulses on credit.

---
 rtl/pkt_tx_pkg.sv | 28 ++
 rtl/pkt_tx_fifo.sv | 58 +++++
 rtl/pkt_tx_engine.sv | 111 +++++++++++
 3 files changed

// File: rtl/pkt_tx_pkg.sv
// Shared types and helpers for the packet transmit engine.
package pkt_tx_pkg;

  localparam int PKT_DATA_W = 32;
  localparam int PKT_CTL_W  = 4;
  // Parity helper input width; narrower payloads are zero-extended, which
  // leaves the XOR reduction unchanged.
  localparam int PKT_MAX_W  = 256;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } pkt_state_e;

  // Bus word layout at the default widths: parity is the MSB.
  typedef struct packed {
    logic                 parity;
    logic [PKT_CTL_W-1:0]  ctl;
    logic [PKT_DATA_W-1:0] data;
  } pkt_word_t;

  // Even parity bit: XOR-reduce of the payload.
  function automatic logic parity_of(input logic [PKT_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/pkt_tx_fifo.sv
// Synchronous FIFO, power-of-two depth, async active-low reset.
// Valid/ready contract: push is honoured only when not full or when a pop
// happens on the same edge; pop is honoured only when not empty.
module pkt_tx_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pkt_tx_engine.sv
// Credit-based packet bus transmitter: ingress FIFO, credit counter,
// INIT/RUN/ERR control FSM and registered bus output.
// Ingress handshake: a beat transfers on a rising edge where in_valid and
// in_ready are both high; in_ready depends only on registered state (and the
// reset pin), never on in_valid.
module pkt_tx_engine
  import pkt_tx_pkg::*;
#(
  parameter int  DATA_W       = PKT_DATA_W,
  parameter int  CTL_W        = PKT_CTL_W,
  parameter int  FIFO_DEPTH   = 4,
  parameter int  INIT_CREDITS = 4,
  localparam int CRED_W       = $clog2(INIT_CREDITS + 1)
) (
  input  logic                    pkt_clk,
  input  logic                    pkt_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [CTL_W-1:0]        in_ctl,
  output logic [DATA_W+CTL_W:0]   bus_tx,
  output logic                    bus_tx_valid,
  input  logic                    credit,
  output logic [CRED_W-1:0]       credit_cnt_o,
  output logic                    cred_err
);

  localparam int              BEAT_W = DATA_W + CTL_W;
  localparam logic [CRED_W-1:0] INIT_C = CRED_W'(INIT_CREDITS);

  pkt_state_e              state_q, state_d;
  logic [CRED_W-1:0]       cred_q, cred_d;
  logic                    err_q, err_d;
  logic [BEAT_W:0]         tx_q, tx_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    send, push;
  logic [BEAT_W-1:0]       fifo_rdata;
  logic                    fifo_full, fifo_empty;

  assign in_ready     = pkt_rst_n && (state_q != ST_ERR) && !fifo_full;
  assign push         = in_valid && in_ready;
  assign send         = (state_q == ST_RUN) && !fifo_empty && (cred_q != '0);
  assign bus_tx       = tx_q;
  assign bus_tx_valid = tx_valid_q;
  assign credit_cnt_o = cred_q;
  assign cred_err     = err_q;

  pkt_tx_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pkt_clk),
    .rst_n (pkt_rst_n),
    .push  (push),
    .pop   (send),
    .wdata ({in_ctl, in_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state, credit arithmetic and output word.
  always_comb begin
    state_d    = state_q;
    cred_d     = cred_q;
    err_d      = err_q;
    tx_d       = tx_q;
    tx_valid_d = send;
    if (send) begin
      tx_d = {parity_of(PKT_MAX_W'(fifo_rdata[DATA_W-1:0])), fifo_rdata};
    end
    case (state_q)
      ST_INIT: begin
        // Credits returned while loading are ignored.
        cred_d  = INIT_C;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (credit && !send) begin
          if (cred_q == INIT_C) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            cred_d = cred_q + CRED_W'(1);
          end
        end else if (send && !credit) begin
          cred_d = cred_q - CRED_W'(1);
        end
      end
      default: ;  // ST_ERR holds everything until reset
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge pkt_clk or negedge pkt_rst_n) begin
    if (!pkt_rst_n) begin
      state_q    <= ST_INIT;
      cred_q     <= '0;
      err_q      <= 1'b0;
      tx_q       <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cred_q     <= cred_d;
      err_q      <= err_d;
      tx_q       <= tx_d;
      tx_valid_q <= tx_valid_d;
    end
  end

endmodule
